// File: rtl/reset_conditioner.sv
// reset_conditioner: front-end reset source for the synthesizer reset tree.
//
// Merges a bouncy push-button, an asynchronous PLL lock and a synchronous soft-reset
// request into one registered active-low master reset. oRST_n is held low for at least
// MIN_PULSE cycles per reset event, and is released only after the PLL lock has been
// qualified as stable and the key is released.
//
// Optional feature: define RST_WDT_EN to add a RUN-state watchdog (cause 4).
//
// Ports:
//   iCLK         system clock
//   iRST         asynchronous active-high power-on/system reset
//   iKEY_n       push-button, active-low, asynchronous
//   iPLL_LOCKED  PLL lock, asynchronous
//   iSOFT_RST    synchronous single-cycle soft-reset request
//   iWDT_KICK    watchdog kick pulse (only used with RST_WDT_EN)
//   oRST_n       conditioned active-low reset
//   oBUSY        high while oRST_n is low
//   oCAUSE       last reset cause: 0 power-on, 1 key, 2 PLL loss, 3 soft, 4 watchdog
//   oEVT_CNT     reset events since power-on, saturating at 255
module reset_conditioner #(
  parameter int unsigned DEBOUNCE_W = 16,
  parameter int unsigned LOCK_W     = 12,
  parameter int unsigned MIN_PULSE  = 255,
  parameter int unsigned WDT_W      = 24
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iKEY_n,
  input  logic       iPLL_LOCKED,
  input  logic       iSOFT_RST,
  input  logic       iWDT_KICK,
  output logic       oRST_n,
  output logic       oBUSY,
  output logic [2:0] oCAUSE,
  output logic [7:0] oEVT_CNT
);

  localparam int unsigned PULSE_W = $clog2(MIN_PULSE);
  localparam logic [PULSE_W-1:0]    PULSE_LAST = PULSE_W'(MIN_PULSE - 1);
  // Last count value before all-ones: the transition fires on the 2^W-1'th cycle.
  localparam logic [DEBOUNCE_W-1:0] DB_LAST    = {{(DEBOUNCE_W-1){1'b1}}, 1'b0};
  localparam logic [LOCK_W-1:0]     LOCK_LAST  = {{(LOCK_W-1){1'b1}}, 1'b0};

  localparam logic [2:0] CausePor  = 3'd0;
  localparam logic [2:0] CauseKey  = 3'd1;
  localparam logic [2:0] CausePll  = 3'd2;
  localparam logic [2:0] CauseSoft = 3'd3;
  localparam logic [2:0] CauseWdt  = 3'd4;

  typedef enum logic [1:0] {StAssert, StQual, StRun} state_e;

  // Synchronizers, edge detectors and debounce
  logic                  key_s1_q, key_s2_q;
  logic                  lock_s1_q, lock_s2_q, lock_prev_q;
  logic                  key_db_q, key_db_d, key_db_prev_q;
  logic [DEBOUNCE_W-1:0] db_cnt_q, db_cnt_d;
  logic                  key_fall, lock_fall;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      key_s1_q      <= 1'b1;
      key_s2_q      <= 1'b1;
      lock_s1_q     <= 1'b0;
      lock_s2_q     <= 1'b0;
      lock_prev_q   <= 1'b0;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      db_cnt_q      <= '0;
    end else begin
      key_s1_q      <= iKEY_n;
      key_s2_q      <= key_s1_q;
      lock_s1_q     <= iPLL_LOCKED;
      lock_s2_q     <= lock_s1_q;
      lock_prev_q   <= lock_s2_q;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      db_cnt_q      <= db_cnt_d;
    end
  end

  always_comb begin
    db_cnt_d = '0;
    key_db_d = key_db_q;
    if (key_s2_q != key_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_db_d = key_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DEBOUNCE_W'(1);
      end
    end
  end

  assign key_fall  = key_db_prev_q & ~key_db_q;
  assign lock_fall = lock_prev_q & ~lock_s2_q;

  // Main FSM state
  state_e             state_q, state_d;
  logic [PULSE_W-1:0] pulse_q, pulse_d;
  logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [2:0]         cause_q, cause_d;
  logic [7:0]         evt_q, evt_d;
  logic               rst_n_q, busy_q;
  logic               wdt_fire;
  logic               trig;
  logic [2:0]         trig_cause;

`ifdef RST_WDT_EN
  localparam logic [WDT_W-1:0] WDT_LAST = {{(WDT_W-1){1'b1}}, 1'b0};

  logic [WDT_W-1:0] wdt_q, wdt_d;

  // Fires on the cycle the counter would reach all-ones; held at zero outside RUN.
  always_comb begin
    wdt_d    = '0;
    wdt_fire = 1'b0;
    if (state_q == StRun && !iWDT_KICK) begin
      if (wdt_q == WDT_LAST) begin
        wdt_fire = 1'b1;
      end else begin
        wdt_d = wdt_q + WDT_W'(1);
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  logic [WDT_W-1:0] unused_wdt_kick;
  assign unused_wdt_kick = {WDT_W{iWDT_KICK}};
  assign wdt_fire        = 1'b0;
`endif

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= StAssert;
      pulse_q    <= '0;
      lock_cnt_q <= '0;
      cause_q    <= CausePor;
      evt_q      <= '0;
      rst_n_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      pulse_q    <= pulse_d;
      lock_cnt_q <= lock_cnt_d;
      cause_q    <= cause_d;
      evt_q      <= evt_d;
      // Registered from the next state so oRST_n/oBUSY move with the state, glitch-free.
      rst_n_q    <= (state_d == StRun);
      busy_q     <= (state_d != StRun);
    end
  end

  // Trigger arbitration: PLL > key > watchdog > soft.
  always_comb begin
    trig       = 1'b1;
    trig_cause = CausePor;
    if (lock_fall) begin
      trig_cause = CausePll;
    end else if (key_fall) begin
      trig_cause = CauseKey;
    end else if (wdt_fire) begin
      trig_cause = CauseWdt;
    end else if (iSOFT_RST) begin
      trig_cause = CauseSoft;
    end else begin
      trig = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pulse_d    = pulse_q;
    lock_cnt_d = lock_cnt_q;
    cause_d    = cause_q;
    evt_d      = evt_q;
    case (state_q)
      StAssert: begin
        lock_cnt_d = '0;
        if (pulse_q == PULSE_LAST) begin
          state_d = StQual;
          pulse_d = '0;
        end else begin
          pulse_d = pulse_q + PULSE_W'(1);
        end
      end
      StQual: begin
        if (iSOFT_RST) begin
          // Restart the pulse; not a new event, cause and count untouched.
          state_d    = StAssert;
          pulse_d    = '0;
          lock_cnt_d = '0;
        end else if (lock_s2_q && key_db_q) begin
          if (lock_cnt_q == LOCK_LAST) begin
            state_d    = StRun;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end else begin
          lock_cnt_d = '0;
        end
      end
      StRun: begin
        if (trig) begin
          state_d    = StAssert;
          pulse_d    = '0;
          lock_cnt_d = '0;
          cause_d    = trig_cause;
          if (evt_q != 8'hFF) begin
            evt_d = evt_q + 8'd1;
          end
        end
      end
      default: state_d = StAssert;
    endcase
  end

  assign oRST_n   = rst_n_q;
  assign oBUSY    = busy_q;
  assign oCAUSE   = cause_q;
  assign oEVT_CNT = evt_q;

endmodule

// File: tb/tb_reset_conditioner.sv
// Self-checking bench for reset_conditioner (DEBOUNCE_W=4, LOCK_W=4, MIN_PULSE=8, WDT_W=6).
// Stimulus pushes expected oRST_n edges (time, level, cause, count) into a queue; a monitor
// pops one entry on every oRST_n change. Define RST_WDT_EN to also exercise the watchdog.
module tb_reset_conditioner;

  logic       iCLK = 1'b0;
  logic       iRST, iKEY_n, iPLL_LOCKED, iSOFT_RST, iWDT_KICK;
  logic       oRST_n, oBUSY;
  logic [2:0] oCAUSE;
  logic [7:0] oEVT_CNT;

  reset_conditioner #(
    .DEBOUNCE_W(4),
    .LOCK_W    (4),
    .MIN_PULSE (8),
    .WDT_W     (6)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iKEY_n     (iKEY_n),
    .iPLL_LOCKED(iPLL_LOCKED),
    .iSOFT_RST  (iSOFT_RST),
    .iWDT_KICK  (iWDT_KICK),
    .oRST_n     (oRST_n),
    .oBUSY      (oBUSY),
    .oCAUSE     (oCAUSE),
    .oEVT_CNT   (oEVT_CNT)
  );

  always #5 iCLK = ~iCLK;

  // cyc equals the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic       rst_n;
    logic [2:0] cause;
    logic [7:0] evt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic prev_rst_n = 1'b0;
  int   m_cause = 0;
  int   m_evt = 0;
  bit   kick_en = 1'b1;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Monitor: every change of oRST_n must match the oldest expected edge.
  always @(negedge iCLK) begin
    if (oRST_n !== prev_rst_n) begin
      prev_rst_n = oRST_n;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL edge_unexpected: cyc=%0d rst_n=%b cause=%0d evt=%0d, no edge expected",
                 cyc, oRST_n, oCAUSE, oEVT_CNT);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.t != cyc || mon_e.rst_n !== oRST_n || mon_e.cause !== oCAUSE ||
            mon_e.evt !== oEVT_CNT || oBUSY !== ~oRST_n) begin
          bad++;
          $display("FAIL edge: got cyc=%0d rst_n=%b busy=%b cause=%0d evt=%0d, want cyc=%0d rst_n=%b busy=%b cause=%0d evt=%0d",
                   cyc, oRST_n, oBUSY, oCAUSE, oEVT_CNT,
                   mon_e.t, mon_e.rst_n, ~mon_e.rst_n, mon_e.cause, mon_e.evt);
        end
      end
    end
  end

  // Background kicker, every ~30 cycles while enabled.
  initial begin
    iWDT_KICK = 1'b0;
    forever begin
      repeat (30) @(posedge iCLK);
      #1;
      if (kick_en) begin
        iWDT_KICK = 1'b1;
        @(posedge iCLK);
        #1;
        iWDT_KICK = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push(input int t, input logic lvl);
    exp_t e;
    e.t = t;
    e.rst_n = lvl;
    e.cause = 3'(m_cause);
    e.evt = 8'(m_evt);
    sb.push_back(e);
  endtask

  // A counted reset event from RUN: fall then rise.
  task automatic expect_event(input int fall_t, input int rise_t, input int cause);
    m_cause = cause;
    if (m_evt < 255) m_evt++;
    push(fall_t, 1'b0);
    push(rise_t, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge iCLK);
      n++;
    end
    @(negedge iCLK);
    total++;
    if (sb.size() != 0 || oRST_n !== 1'b1 || oBUSY !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: pending=%0d rst_n=%b busy=%b, want pending=0 rst_n=1 busy=0",
               name, sb.size(), oRST_n, oBUSY);
    end
    sb.delete();
    @(posedge iCLK);
    #1;
  endtask

  task automatic soft_pulse();
    int n = cyc;
    iSOFT_RST = 1'b1;
    expect_event(n + 1, n + 24, 3);
    tick(1);
    iSOFT_RST = 1'b0;
  endtask

  // Key held low for 'hold' cycles; optionally a soft request lands with key_fall.
  task automatic key_press(input int hold, input bit with_soft);
    int k = cyc;
    iKEY_n = 1'b0;
    expect_event(k + 18, imax(k + 27, k + hold + 18) + 14, 1);
    for (int i = 1; i <= hold; i++) begin
      tick(1);
      iSOFT_RST = (with_soft && cyc == k + 17);
    end
    iSOFT_RST = 1'b0;
    iKEY_n = 1'b1;
  endtask

  task automatic pll_drop(input int d);
    int n = cyc;
    iPLL_LOCKED = 1'b0;
    expect_event(n + 3, imax(n + 12, n + d + 3) + 14, 2);
    tick(d);
    iPLL_LOCKED = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: cyc=%0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int t0, lk, n, f, n2, r;
    iRST = 1'b1;
    iKEY_n = 1'b1;
    iPLL_LOCKED = 1'b0;
    iSOFT_RST = 1'b0;

    // Power-on
    tick(5);
    check("por_rst_n", oRST_n, 1'b0);
    check("por_busy", oBUSY, 1'b1);
    check("por_cause", oCAUSE, 3'd0);
    check("por_evt", oEVT_CNT, 8'd0);
    iRST = 1'b0;
    t0 = cyc;
    tick(20);
    iPLL_LOCKED = 1'b1;
    lk = cyc;
    push(imax(t0 + 9, lk + 3) + 14, 1'b1);
    wait_idle("poweron");

    // Key bounce: glitches shorter than the debounce window never reset.
    for (int i = 0; i < 8; i++) begin
      iKEY_n = 1'b0;
      tick((i == 0) ? 14 : $urandom_range(1, 14));
      iKEY_n = 1'b1;
      tick($urandom_range(2, 6));
    end
    tick(30);
    check("bounce_rst_n", oRST_n, 1'b1);
    check("bounce_cause", oCAUSE, 3'd0);
    check("bounce_evt", oEVT_CNT, 8'd0);

    // Solid presses, including the exact 15-cycle boundary.
    key_press(20, 1'b0);
    wait_idle("key20");
    key_press(15, 1'b0);
    wait_idle("key15");
    for (int i = 0; i < 2; i++) begin
      key_press($urandom_range(16, 45), 1'b0);
      wait_idle("key_rand");
    end

    // Soft + key_fall together: key wins, one count.
    key_press(20, 1'b1);
    wait_idle("key_soft");
    check("simul_cause", oCAUSE, 3'd1);
    check("simul_evt", oEVT_CNT, 32'(m_evt));

    // PLL drops
    pll_drop(1);
    wait_idle("pll1");
    for (int i = 0; i < 3; i++) begin
      pll_drop($urandom_range(1, 14));
      wait_idle("pll_rand");
    end

    // Soft resets
    for (int i = 0; i < 3; i++) begin
      tick($urandom_range(0, 5));
      soft_pulse();
      wait_idle("soft");
    end

    // Soft request in QUAL restarts ASSERT without counting.
    for (int i = 0; i < 2; i++) begin
      n = cyc;
      iSOFT_RST = 1'b1;
      f = n + 1;
      r = $urandom_range(0, 13);
      n2 = f + 8 + r;
      m_cause = 3;
      if (m_evt < 255) m_evt++;
      push(f, 1'b0);
      push(n2 + 24, 1'b1);
      tick(1);
      iSOFT_RST = 1'b0;
      tick(n2 - cyc);
      iSOFT_RST = 1'b1;
      tick(1);
      iSOFT_RST = 1'b0;
      wait_idle("soft_qual");
    end

`ifdef RST_WDT_EN
    // No kick: watchdog fires 63 cycles into RUN.
    kick_en = 1'b0;
    tick(3);
    n = cyc;
    iSOFT_RST = 1'b1;
    expect_event(n + 1, n + 24, 3);
    expect_event(n + 24 + 63, n + 24 + 63 + 23, 4);
    tick(1);
    iSOFT_RST = 1'b0;
    tick(n + 24 + 63 - cyc + 1);
    kick_en = 1'b1;
    wait_idle("wdt_fire");
    check("wdt_cause", oCAUSE, 3'd4);
    tick(150);
    check("wdt_kicked_rst_n", oRST_n, 1'b1);
    check("wdt_kicked_cause", oCAUSE, 3'd4);
`else
    // Without the watchdog, a long unkicked RUN stays up.
    kick_en = 1'b0;
    tick(150);
    check("nowdt_rst_n", oRST_n, 1'b1);
    check("nowdt_evt", oEVT_CNT, 32'(m_evt));
    kick_en = 1'b1;
`endif

    // Saturation of the event counter.
    for (int i = 0; i < 256; i++) begin
      soft_pulse();
      wait_idle("sat");
    end
    check("sat_evt", oEVT_CNT, 8'd255);
    check("sat_cause", oCAUSE, 3'd3);

    // iRST in the middle of QUAL.
    n = cyc;
    iSOFT_RST = 1'b1;
    expect_event(n + 1, n + 24, 3);
    tick(1);
    iSOFT_RST = 1'b0;
    tick(8 + $urandom_range(0, 10));
    #2;
    iRST = 1'b1;
    #1;
    check("midrst_rst_n", oRST_n, 1'b0);
    check("midrst_busy", oBUSY, 1'b1);
    check("midrst_cause", oCAUSE, 3'd0);
    check("midrst_evt", oEVT_CNT, 8'd0);
    sb.delete();
    m_cause = 0;
    m_evt = 0;
    tick(2);
    iRST = 1'b0;
    n = cyc;
    push(n + 23, 1'b1);
    wait_idle("midrst");
    check("midrst_final_evt", oEVT_CNT, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
